// File: rtl/xy_change_logger.sv
// Timestamps every change of the {x,y} pair and queues {time,x,y} events in a
// first-word-fall-through FIFO read through a valid/ready port.
module xy_change_logger #(
  parameter int TS_WIDTH   = 16,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  x_in,
  input  logic                  y_in,
  output logic                  evt_valid,
  input  logic                  evt_ready,
  output logic [TS_WIDTH-1:0]   evt_time,
  output logic                  evt_x,
  output logic                  evt_y,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow,
  output logic [7:0]            drop_count
);

  localparam int DEPTH   = 1 << DEPTH_LOG2;
  localparam int ENTRY_W = TS_WIDTH + 2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hff) ? v : v + 8'd1;
  endfunction

  logic [0:0]            state;
  logic [1:0]            prev_xy;
  logic [TS_WIDTH-1:0]   ts;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2:0]   count_r;
  logic                  overflow_r;
  logic [7:0]            drop_r;
  logic [ENTRY_W-1:0]    mem [DEPTH];

  logic [1:0]            cur_xy;
  logic                  push_req;
  logic                  pop;
  logic                  full;
  logic                  push_ok;
  logic                  drop;
  logic [DEPTH_LOG2:0]   count_next;
  logic [ENTRY_W-1:0]    head;

  assign cur_xy   = {x_in, y_in};
  assign push_req = (state == ST_INIT) || (cur_xy != prev_xy);
  assign full     = (count_r == FULL_CNT);
  assign pop      = evt_valid && evt_ready;
  // A full FIFO still takes a push when the head leaves on the same edge.
  assign push_ok  = push_req && (!full || pop);
  assign drop     = push_req && full && !pop;
  assign count_next = count_r + {{DEPTH_LOG2{1'b0}}, push_ok}
                              - {{DEPTH_LOG2{1'b0}}, pop};

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_INIT;
      prev_xy    <= 2'b00;
      ts         <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count_r    <= '0;
      overflow_r <= 1'b0;
      drop_r     <= 8'd0;
    end else begin
      state   <= ST_RUN;
      ts      <= ts + 1'b1;
      count_r <= count_next;
      // prev_xy follows the input even for dropped events.
      if (push_req) prev_xy <= cur_xy;
      if (push_ok)  wr_ptr  <= wr_ptr + 1'b1;
      if (pop)      rd_ptr  <= rd_ptr + 1'b1;
      if (drop) begin
        overflow_r <= 1'b1;
        drop_r     <= sat_inc8(drop_r);
      end
    end
  end

  // Storage array holds data only and is never reset.
  always_ff @(posedge clk) begin
    if (!reset && push_ok) mem[wr_ptr] <= {ts, cur_xy};
  end

  // Output stage: head gated to zero while empty so nothing reads back X.
  assign head       = mem[rd_ptr];
  assign evt_valid  = (count_r != '0);
  assign evt_time   = evt_valid ? head[ENTRY_W-1:2] : '0;
  assign evt_x      = evt_valid ? head[1] : 1'b0;
  assign evt_y      = evt_valid ? head[0] : 1'b0;
  assign count      = count_r;
  assign overflow   = overflow_r;
  assign drop_count = drop_r;

endmodule

// File: tb/tb_xy_change_logger.sv
// Bench for xy_change_logger: directed scenarios plus random traffic checked
// against a queue-based event model.
module tb_xy_change_logger;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        x_in = 1'b0;
  logic        y_in = 1'b0;
  logic        evt_ready = 1'b0;

  logic        evt_valid;
  logic [15:0] evt_time;
  logic        evt_x, evt_y;
  logic [3:0]  count;
  logic        overflow;
  logic [7:0]  drop_count;

  logic        w_evt_valid;
  logic [3:0]  w_evt_time;
  logic        w_evt_x, w_evt_y;
  logic [3:0]  w_count;
  logic        w_overflow;
  logic [7:0]  w_drop_count;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: pending events as {time, x, y}
  logic [17:0] m_q[$];
  int          m_ts = 0;
  bit          m_first = 1'b1;
  logic [1:0]  m_prev = 2'b00;
  bit          m_ovf = 1'b0;
  int          m_drop = 0;

  always #5 clk = ~clk;

  xy_change_logger #(.TS_WIDTH(16), .DEPTH_LOG2(3)) dut (
    .clk(clk), .reset(reset), .x_in(x_in), .y_in(y_in),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_time(evt_time),
    .evt_x(evt_x), .evt_y(evt_y), .count(count), .overflow(overflow),
    .drop_count(drop_count)
  );

  xy_change_logger #(.TS_WIDTH(4), .DEPTH_LOG2(3)) dut_w (
    .clk(clk), .reset(reset), .x_in(x_in), .y_in(y_in),
    .evt_valid(w_evt_valid), .evt_ready(evt_ready), .evt_time(w_evt_time),
    .evt_x(w_evt_x), .evt_y(w_evt_y), .count(w_count), .overflow(w_overflow),
    .drop_count(w_drop_count)
  );

  // Drive one clock edge and advance the model; outputs are sampled 1ns after.
  task automatic tick(input logic x, input logic y, input logic r, input logic rs);
    @(negedge clk);
    x_in = x; y_in = y; evt_ready = r; reset = rs;
    if (rs) begin
      m_q.delete(); m_ts = 0; m_first = 1'b1; m_ovf = 1'b0; m_drop = 0;
    end else begin
      if (r && m_q.size() > 0) void'(m_q.pop_front());
      if (m_first || {x, y} != m_prev) begin
        if (m_q.size() < 8) m_q.push_back({16'(m_ts), x, y});
        else begin
          m_ovf = 1'b1;
          if (m_drop < 255) m_drop++;
        end
      end
      m_prev = {x, y};
      m_first = 1'b0;
      m_ts = (m_ts + 1) % 65536;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    tick(1'b0, 1'b1, 1'b1, 1'b1);
    tick(1'b0, 1'b1, 1'b1, 1'b1);
    vectors++;
    if (evt_valid !== 1'b0 || count !== 4'd0 || overflow !== 1'b0 || drop_count !== 8'd0 ||
        evt_time !== 16'd0 || evt_x !== 1'b0 || evt_y !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: valid=%b count=%0d ovf=%b drops=%0d time=%0d x=%b y=%b, required all zero",
               evt_valid, count, overflow, drop_count, evt_time, evt_x, evt_y);
    end
  endtask

  task automatic test_single_and_toggle();
    logic x;
    tick(1'b0, 1'b1, 1'b1, 1'b0);  // edge 0
    vectors++;
    if (evt_valid !== 1'b1 || count !== 4'd1 || evt_time !== 16'd0 || evt_x !== 1'b0 || evt_y !== 1'b1) begin
      miscompares++;
      $display("FAIL initial_event: valid=%b count=%0d time=%0d x=%b y=%b, required 1 1 0 0 1",
               evt_valid, count, evt_time, evt_x, evt_y);
    end
    for (int e = 1; e <= 12; e++) begin
      x = (e >= 5 && e < 9);
      tick(x, 1'b1, 1'b1, 1'b0);
      vectors++;
      if (e == 5 || e == 9) begin
        if (evt_valid !== 1'b1 || count !== 4'd1 || evt_time !== 16'(e) || evt_x !== x || evt_y !== 1'b1) begin
          miscompares++;
          $display("FAIL toggle_event edge %0d: valid=%b count=%0d time=%0d x=%b y=%b, required 1 1 %0d %b 1",
                   e, evt_valid, count, evt_time, evt_x, evt_y, e, x);
        end
      end else if (evt_valid !== 1'b0 || count !== 4'd0) begin
        miscompares++;
        $display("FAIL no_event edge %0d: valid=%b count=%0d, required 0 0", e, evt_valid, count);
      end
    end
  endtask

  task automatic test_simultaneous();
    tick(1'b0, 1'b0, 1'b1, 1'b1);
    for (int e = 0; e <= 4; e++) begin
      tick(e >= 3, e >= 3, 1'b1, 1'b0);
      if (e == 3) begin
        vectors++;
        if (count !== 4'd1 || evt_time !== 16'd3 || evt_x !== 1'b1 || evt_y !== 1'b1) begin
          miscompares++;
          $display("FAIL both_flip: count=%0d time=%0d x=%b y=%b, required 1 3 1 1",
                   count, evt_time, evt_x, evt_y);
        end
      end
    end
    vectors++;
    if (count !== 4'd0 || evt_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL both_flip_single: count=%0d valid=%b, required 0 0", count, evt_valid);
    end
  endtask

  task automatic fill_overflow(input string tag);
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    for (int e = 0; e <= 9; e++) begin
      tick(logic'(e % 2), 1'b0, 1'b0, 1'b0);
      vectors++;
      if (evt_valid !== 1'b1 || evt_time !== 16'd0 || evt_x !== 1'b0 || evt_y !== 1'b0) begin
        miscompares++;
        $display("FAIL %s_head_hold edge %0d: valid=%b time=%0d x=%b y=%b, required 1 0 0 0",
                 tag, e, evt_valid, evt_time, evt_x, evt_y);
      end
    end
    vectors++;
    if (count !== 4'd8 || overflow !== 1'b1 || drop_count !== 8'd2) begin
      miscompares++;
      $display("FAIL %s_full: count=%0d ovf=%b drops=%0d, required 8 1 2", tag, count, overflow, drop_count);
    end
  endtask

  task automatic test_overflow_and_full_push_pop();
    int exp_t[8] = '{1, 2, 3, 4, 5, 6, 7, 10};
    fill_overflow("ovf");
    tick(1'b0, 1'b0, 1'b1, 1'b0);  // edge 10: pop head and push change together
    vectors++;
    if (count !== 4'd8 || drop_count !== 8'd2 || evt_time !== 16'd1 || evt_x !== 1'b1) begin
      miscompares++;
      $display("FAIL full_push_pop: count=%0d drops=%0d time=%0d x=%b, required 8 2 1 1",
               count, drop_count, evt_time, evt_x);
    end
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (evt_valid !== 1'b1 || evt_time !== 16'(exp_t[i])) begin
        miscompares++;
        $display("FAIL drain entry %0d: valid=%b time=%0d, required 1 %0d", i, evt_valid, evt_time, exp_t[i]);
      end
      tick(1'b0, 1'b0, 1'b1, 1'b0);
    end
    vectors++;
    if (evt_valid !== 1'b0 || count !== 4'd0 || overflow !== 1'b1) begin
      miscompares++;
      $display("FAIL drain_empty: valid=%b count=%0d ovf=%b, required 0 0 1", evt_valid, count, overflow);
    end
  endtask

  task automatic test_reset_mid();
    fill_overflow("mid");
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 1'b1, 1'b0);
    vectors++;
    if (count !== 4'd5 || overflow !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_prefill: count=%0d ovf=%b, required 5 1", count, overflow);
    end
    tick(1'b1, 1'b0, 1'b0, 1'b1);
    vectors++;
    if (count !== 4'd0 || evt_valid !== 1'b0 || overflow !== 1'b0 || drop_count !== 8'd0) begin
      miscompares++;
      $display("FAIL mid_reset: count=%0d valid=%b ovf=%b drops=%0d, required 0 0 0 0",
               count, evt_valid, overflow, drop_count);
    end
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    vectors++;
    if (evt_valid !== 1'b1 || evt_time !== 16'd0 || evt_x !== 1'b1 || count !== 4'd1) begin
      miscompares++;
      $display("FAIL mid_restart: valid=%b time=%0d x=%b count=%0d, required 1 0 1 1",
               evt_valid, evt_time, evt_x, count);
    end
  endtask

  task automatic test_drop_saturate();
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    for (int e = 0; e < 270; e++) tick(logic'(e % 2), 1'b0, 1'b0, 1'b0);
    vectors++;
    if (drop_count !== 8'd255 || overflow !== 1'b1 || count !== 4'd8 || evt_time !== 16'd0) begin
      miscompares++;
      $display("FAIL drop_saturate: drops=%0d ovf=%b count=%0d time=%0d, required 255 1 8 0",
               drop_count, overflow, count, evt_time);
    end
  endtask

  task automatic test_wrap();
    tick(1'b0, 1'b0, 1'b1, 1'b1);
    for (int e = 0; e <= 17; e++) tick(e == 17, 1'b0, 1'b1, 1'b0);
    vectors++;
    if (w_evt_valid !== 1'b1 || w_evt_time !== 4'd1 || w_evt_x !== 1'b1 || w_count !== 4'd1) begin
      miscompares++;
      $display("FAIL ts_wrap: valid=%b time=%0d x=%b count=%0d, required 1 1 1 1",
               w_evt_valid, w_evt_time, w_evt_x, w_count);
    end
    vectors++;
    if (evt_time !== 16'd17) begin
      miscompares++;
      $display("FAIL ts_nowrap: time=%0d, required 17", evt_time);
    end
  endtask

  task automatic test_random();
    logic rx = 1'b0, ry = 1'b0, rr, rs;
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(3) == 0) rx = ~rx;
      if ($urandom_range(4) == 0) ry = ~ry;
      rr = ($urandom_range(2) == 0);
      rs = ($urandom_range(149) == 0);
      tick(rx, ry, rr, rs);
      vectors++;
      if (evt_valid !== (m_q.size() > 0) || count !== 4'(m_q.size()) ||
          overflow !== m_ovf || drop_count !== 8'(m_drop)) begin
        miscompares++;
        $display("FAIL random_ctrl cyc %0d: valid=%b count=%0d ovf=%b drops=%0d, required %b %0d %b %0d",
                 c, evt_valid, count, overflow, drop_count, m_q.size() > 0, m_q.size(), m_ovf, m_drop);
      end
      if (m_q.size() > 0) begin
        vectors++;
        if ({evt_time, evt_x, evt_y} !== m_q[0]) begin
          miscompares++;
          $display("FAIL random_head cyc %0d: time=%0d x=%b y=%b, required %0d %b %b",
                   c, evt_time, evt_x, evt_y, m_q[0][17:2], m_q[0][1], m_q[0][0]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_and_toggle();
    test_simultaneous();
    test_overflow_and_full_push_pop();
    test_reset_mid();
    test_drop_saturate();
    test_wrap();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/xy_change_logger.md
Name: xy_change_logger

Overview:
- Downstream consumer of the two 1-bit pass-through outputs (x, y) of the instance-chain buffers.
- Detects every change of the {x,y} pair and timestamps it with a free-running cycle counter.
- Queues the events in a small first-word-fall-through FIFO with a valid/ready output port for a host reader.
- Provides a synthesizable, clocked equivalent of the pair-value monitor used in simulation.

Parameters:
- TS_WIDTH, 16, width of the timestamp counter and of evt_time.
- DEPTH_LOG2, 3, log2 of FIFO depth (depth = 8 by default).

Ports:
- clk  input  1  single clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- x_in  input  1  x signal; already synchronous to clk.
- y_in  input  1  y signal; already synchronous to clk.
- evt_valid  output  1  head FIFO entry is valid.
- evt_ready  input  1  reader accepts head entry when evt_valid && evt_ready.
- evt_time  output  TS_WIDTH  timestamp of head entry.
- evt_x  output  1  x value of head entry.
- evt_y  output  1  y value of head entry.
- count  output  DEPTH_LOG2+1  current FIFO occupancy.
- overflow  output  1  sticky: at least one event was dropped.
- drop_count  output  8  number of dropped events, saturating at 255.

Behaviour:
- Reset (edge with reset=1):
  - FIFO empties; evt_valid=0, count=0.
  - evt_time, evt_x and evt_y go to 0.
  - overflow=0, drop_count=0, timestamp counter ts=0.
  - The FSM goes to INIT.
  - Reset mid-operation discards all queued entries in the same edge.
- Timestamp:
  - ts increments by 1 on every non-reset edge.
  - ts wraps modulo 2^TS_WIDTH with no flag.
  - Edge n after reset deassertion (0-based) stamps with value n mod 2^TS_WIDTH.
- FSM, INIT state:
  - On the first non-reset edge, push an event {ts, x_in, y_in} unconditionally.
  - Load prev_xy <= {x_in, y_in}.
  - Go to RUN.
- FSM, RUN state:
  - On each edge where {x_in, y_in} != prev_xy, push {ts, x_in, y_in} and update prev_xy.
  - A simultaneous change of both bits produces one event, not two.
  - prev_xy updates even when the event is dropped, so no spurious re-detection occurs.
- Latency: an input change sampled at edge k produces evt_valid=1 immediately after edge k when the FIFO was empty. There is no combinational bypass from inputs to outputs.
- FIFO:
  - First-word-fall-through; head entry is presented on evt_* whenever count>0.
  - Pop occurs on an edge with evt_valid && evt_ready.
  - evt_time, evt_x and evt_y hold stable while evt_valid && !evt_ready.
  - Outputs are don't-care when evt_valid=0, but must not be X after reset.
- Push and pop, same edge:
  - When empty: pop is ignored (evt_valid=0); push is accepted; count=1 after the edge.
  - When full: both are accepted; count stays at 2^DEPTH_LOG2; no drop.
  - When partially filled: both occur; count is unchanged.
- Full with push and no pop:
  - The event is dropped and overflow is set (sticky until reset).
  - drop_count increments, saturating at 255.
  - Existing entries are untouched.
- Pointers are DEPTH_LOG2 wide and wrap naturally; the full/empty decision uses count.

Test Plan:
- Reset for 2 cycles, then release with x=0, y=1 held and evt_ready=1:
  - exactly one event {time=0, x=0, y=1}, visible after edge 0, popped at edge 1;
  - no further events.
- Continuing scenario 1 (evt_ready=1), toggle x_in to 1 sampled at edge 5 and back to 0 at edge 9:
  - events {5,1,1} then {9,0,1}; count never exceeds 1.
- x and y flip simultaneously at edge 3:
  - a single event {3, new x, new y}.
- evt_ready=0; initial event plus x toggling every edge for 9 edges (10 events, DEPTH=8):
  - count=8, overflow=1, drop_count=2;
  - stored times 0..7;
  - evt_* hold {0,…} stable throughout.
- FIFO full, then one edge with evt_ready=1 and an input change:
  - head entry is popped and the new event is pushed;
  - count stays 8; drop_count is unchanged.
- Reset mid-operation with count=5 and overflow=1:
  - after the reset edge, count=0, evt_valid=0, overflow=0, drop_count=0;
  - after release, the new initial event has time=0.
- TS_WIDTH=4, x toggles sampled at edge 17:
  - event time=1, confirming wrap-around.
